// File: rtl/sm_digit_serializer_pkg.sv
// Shared types and constants for the signed-word to decimal digit serializer.
package sm_digit_pkg;

   localparam int unsigned DEC_BASE = 10;
   localparam int unsigned DIGIT_W  = 4;
   localparam int unsigned TENS_W   = 3;

   typedef logic [DIGIT_W-1:0] digit_t;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      EMIT_TENS,
      EMIT_ONES
   } state_e;

endpackage

// File: rtl/sm_digit_serializer_if.sv
// Word-in / digit-out handshake bundle of the digit serializer.
interface sm_digit_serializer_if #(
   parameter int unsigned DATA_W = 6
);
   import sm_digit_pkg::*;

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   digit_t            out_digit;
   logic              out_neg;
   logic              out_first;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;

   // Producer of words and consumer of digits.
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_digit, out_neg, out_first, out_last, out_valid
   );

   // The serializer itself.
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_digit, out_neg, out_first, out_last, out_valid
   );

endinterface

// File: rtl/sm_digit_serializer_div10_iter.sv
// Iterative divide-by-ten: rem/tens register pair, one subtraction per step.
module div10_iter
   import sm_digit_pkg::*;
#(
   parameter int unsigned REM_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [REM_W-1:0]  load_val_i,
   input  logic              step_i,
   output logic [REM_W-1:0]  rem_o,
   output logic [TENS_W-1:0] tens_o,
   output logic              done_o
);

   // Wide enough to compare any rem against the base without truncating it.
   localparam int unsigned CMP_W = 8;

   logic [REM_W-1:0]  rem_q,  rem_d;
   logic [TENS_W-1:0] tens_q, tens_d;
   logic              done_q, done_d;

   // Next rem/tens: load a fresh magnitude or take one subtract-by-ten step.
   always_comb begin
      rem_d  = rem_q;
      tens_d = tens_q;
      done_d = done_q;
      if (load_i) begin
         rem_d  = load_val_i;
         tens_d = '0;
         done_d = CMP_W'(load_val_i) < CMP_W'(DEC_BASE);
      end else if (step_i && !done_q) begin
         rem_d  = rem_q - REM_W'(DEC_BASE);
         tens_d = tens_q + TENS_W'(1);
         done_d = CMP_W'(rem_d) < CMP_W'(DEC_BASE);
      end
   end

   // Quotient/remainder registers; done tracks rem < 10 alongside them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q  <= '0;
         tens_q <= '0;
         done_q <= 1'b1;
      end else begin
         rem_q  <= rem_d;
         tens_q <= tens_d;
         done_q <= done_d;
      end
   end

   assign rem_o  = rem_q;
   assign tens_o = tens_q;
   assign done_o = done_q;

endmodule

// File: rtl/sm_digit_serializer.sv
// Accepts one sign/one's-complement word, streams its decimal digits MSD first.
module sm_digit_serializer
   import sm_digit_pkg::*;
#(
   parameter int unsigned DATA_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   sm_digit_serializer_if.slave bus
);

   localparam int unsigned REM_W = DATA_W - 1;

   state_e            state_q;
   logic              sign_c;
   logic [REM_W-1:0]  mag_c;
   logic              load_c;
   logic              step_c;
   logic [REM_W-1:0]  rem;
   logic [TENS_W-1:0] tens;
   logic              done;

   digit_t            out_digit_q;
   logic              out_neg_q;
   logic              out_first_q;
   logic              out_last_q;
   logic              out_valid_q;

   // Magnitude of the incoming word: the inverted payload when the sign is set.
   assign sign_c = bus.in_data[DATA_W-1];
   assign mag_c  = sign_c ? ~bus.in_data[DATA_W-2:0] : bus.in_data[DATA_W-2:0];
   assign load_c = (state_q == IDLE) && bus.in_valid;
   assign step_c = (state_q == CONV) && !done;

   div10_iter #(
      .REM_W (REM_W)
   ) u_div10 (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load_c),
      .load_val_i (mag_c),
      .step_i     (step_c),
      .rem_o      (rem),
      .tens_o     (tens),
      .done_o     (done)
   );

   // Control FSM with registered digit/flag outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         out_digit_q <= '0;
         out_neg_q   <= 1'b0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  // Negative zero is reported as plain zero.
                  out_neg_q <= sign_c && (mag_c != '0);
                  state_q   <= CONV;
               end
            end
            CONV: begin
               if (done) begin
                  out_valid_q <= 1'b1;
                  out_first_q <= 1'b1;
                  if (tens != '0) begin
                     out_digit_q <= DIGIT_W'(tens);
                     out_last_q  <= 1'b0;
                     state_q     <= EMIT_TENS;
                  end else begin
                     out_digit_q <= DIGIT_W'(rem);
                     out_last_q  <= 1'b1;
                     state_q     <= EMIT_ONES;
                  end
               end
            end
            EMIT_TENS: begin
               if (bus.out_ready) begin
                  out_digit_q <= DIGIT_W'(rem);
                  out_first_q <= 1'b0;
                  out_last_q  <= 1'b1;
                  state_q     <= EMIT_ONES;
               end
            end
            EMIT_ONES: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_digit = out_digit_q;
   assign bus.out_neg   = out_neg_q;
   assign bus.out_first = out_first_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sm_digit_serializer.sv
// Self-checking bench: digit-stream model plus directed latency/backpressure/reset cases.
module tb_sm_digit_serializer;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_errors;

   // Expected and observed digit beats, packed as {neg, first, last, digit}.
   logic [6:0] exp_q[$];
   logic [6:0] obs_q[$];

   sm_digit_serializer_if #(.DATA_W(6)) bus ();

   sm_digit_serializer #(.DATA_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Decimal expansion of a word, straight from its numeric value.
   function automatic void model_push(input logic [5:0] d);
      int mag;
      int t;
      int o;
      logic neg;
      mag = d[5] ? int'(~d[4:0] & 5'h1f) : int'(d[4:0]);
      neg = d[5] && (mag != 0);
      t = mag / 10;
      o = mag % 10;
      if (t != 0) exp_q.push_back({neg, 1'b1, 1'b0, 4'(t)});
      exp_q.push_back({neg, (t == 0), 1'b1, 4'(o)});
   endfunction

   // Every presented digit is checked against the head of the model stream.
   always @(negedge clk) begin
      if (!rst && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_digit", 1, 0);
         end else begin
            chk("digit_beat", int'({bus.out_neg, bus.out_first, bus.out_last, bus.out_digit}),
                int'(exp_q[0]));
            if (bus.out_ready) begin
               obs_q.push_back({bus.out_neg, bus.out_first, bus.out_last, bus.out_digit});
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // All tasks start and end at 1 time unit after a rising edge.
   task automatic send(input logic [5:0] d, output int acc);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) chk("send_timeout", 0, 1);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      acc = cyc;
      model_push(d);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int at);
      int n;
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.out_valid) chk("valid_timeout", 0, 1);
      at = cyc;
   endtask

   task automatic wait_ready(output int at);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) chk("ready_timeout", 0, 1);
      at = cyc;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0 || bus.out_valid) chk("drain_timeout", 0, 1);
   endtask

   // Hand-computed digit beats pin the model's expansion.
   task automatic expect_obs(input string name, input int n,
                             input logic [6:0] e0, input logic [6:0] e1);
      logic [6:0] e;
      chk({name, "_count"}, obs_q.size(), n);
      for (int i = 0; i < n && i < obs_q.size(); i++) begin
         e = (i == 0) ? e0 : e1;
         chk(name, int'(obs_q[i]), int'(e));
      end
      obs_q.delete();
   endtask

   initial begin
      int acc;
      int at;
      n_checks = 0;
      n_errors = 0;
      cyc = 0;
      rst = 1'b1;
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_out_fields",
          int'({bus.out_neg, bus.out_first, bus.out_last, bus.out_digit}), 0);
      chk("idle_in_ready", bus.in_ready, 1);

      // +7: single digit, valid two cycles after accept
      send(6'b000111, acc);
      wait_valid(at);
      chk("lat_7", at - acc, 2);
      drain();
      expect_obs("w7", 1, 7'b0_1_1_0111, 7'b0);

      // +31: two digits, next accept seven cycles later
      send(6'b011111, acc);
      wait_ready(at);
      chk("period_31", at - acc, 7);
      drain();
      expect_obs("w31", 2, 7'b0_1_0_0011, 7'b0_0_1_0001);

      // -31
      send(6'b100000, acc);
      drain();
      expect_obs("wm31", 2, 7'b1_1_0_0011, 7'b1_0_1_0001);

      // negative zero and zero
      send(6'b111111, acc);
      drain();
      expect_obs("wnz", 1, 7'b0_1_1_0000, 7'b0);
      send(6'b000000, acc);
      drain();
      expect_obs("w0", 1, 7'b0_1_1_0000, 7'b0);

      // boundaries around the base, and a negative ten
      send(6'b001001, acc);
      drain();
      expect_obs("w9", 1, 7'b0_1_1_1001, 7'b0);
      send(6'b001010, acc);
      wait_valid(at);
      chk("lat_10", at - acc, 3);
      drain();
      expect_obs("w10", 2, 7'b0_1_0_0001, 7'b0_0_1_0000);
      send(6'b110101, acc);
      drain();
      expect_obs("wm10", 2, 7'b1_1_0_0001, 7'b1_0_1_0000);

      // +20 under backpressure, with a stray in_valid pulse while busy
      bus.out_ready = 1'b0;
      send(6'b010100, acc);
      wait_valid(at);
      chk("lat_20", at - acc, 4);
      for (int i = 0; i < 5; i++) begin
         chk("hold_digit", bus.out_digit, 2);
         chk("hold_first", bus.out_first, 1);
         chk("hold_neg", bus.out_neg, 0);
         chk("hold_in_ready", bus.in_ready, 0);
         bus.in_valid = (i == 2);
         bus.in_data  = 6'b000101;
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drain();
      expect_obs("w20", 2, 7'b0_1_0_0010, 7'b0_0_1_0000);
      repeat (4) @(posedge clk);
      #1;
      chk("stray_ignored", bus.out_valid, 0);

      // reset in the middle of converting +25, then +4
      send(6'b011001, acc);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_in_ready", bus.in_ready, 1);
      exp_q.delete();
      obs_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      chk("postrst_in_ready", bus.in_ready, 1);
      send(6'b000100, acc);
      wait_valid(at);
      chk("lat_4", at - acc, 2);
      drain();
      expect_obs("w4", 1, 7'b0_1_1_0100, 7'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("final_idle", bus.out_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sm_digit_serializer.md
# sm_digit_serializer

Downstream of the most-significant-digit stage: accepts one signed word per handshake in the same sign/one's-complement format, with a 6-bit default. Converts the magnitude to decimal with an iterative subtract-by-ten engine. Streams the decimal digits out most-significant first, each with a sign flag and first/last framing, under valid/ready flow control. Feeds the digit display / UART formatter stage.

## Interface
- DATA_W, 6, input word width; legal range 2..7, so the magnitude is ≤ 63 and at most two digits are produced.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  signed word. MSB = sign. Magnitude is `in_data[DATA_W-2:0]` if the sign is 0, or its bitwise inverse if the sign is 1.
- in_valid  in  1  word available.
- in_ready  out  1  block can accept a word.
- out_digit  out  4  BCD digit, 0..9.
- out_neg  out  1  word is negative; constant across all digits of one word.
- out_first  out  1  digit is the first of its word.
- out_last  out  1  digit is the last of its word.
- out_valid  out  1  digit/flags valid.
- out_ready  in  1  consumer accepts the digit.

## Operation
- States:
  - IDLE: accept a word.
  - CONV: divide by ten, one step per cycle.
  - EMIT_TENS: present the tens digit.
  - EMIT_ONES: present the ones digit.
- in_ready = (state == IDLE). It is decoded combinationally from the state register, with no bypass.
- IDLE, when in_valid is high:
  - Latch the magnitude into rem (DATA_W-1 bits) and clear tens (3 bits).
  - neg = sign & (magnitude != 0). Negative zero (all ones) is normalised to neg = 0.
  - Go to CONV.
- CONV, each cycle:
  - If rem ≥ 10: rem ← rem − 10, tens ← tens + 1, stay in CONV.
  - Otherwise: go to EMIT_TENS if tens ≠ 0, else go to EMIT_ONES.
- EMIT_TENS:
  - out_digit = tens, out_first = 1, out_last = 0.
  - On out_ready, go to EMIT_ONES.
- EMIT_ONES:
  - out_digit = rem, out_last = 1.
  - out_first = 1 if no tens digit was emitted for this word.
  - On out_ready, go to IDLE.
- Leading zeros are suppressed. Magnitude 0 emits a single digit 0 with first = last = 1.
- out_valid = state ∈ {EMIT_TENS, EMIT_ONES}.
- All out_* fields are registered. They are stable while out_valid is high and out_ready is low.
- Arithmetic is unsigned. rem never underflows, because subtraction happens only when rem ≥ 10. tens ≤ 6.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1.
  - out_valid = 0.
  - out_digit = 0, out_neg = 0, out_first = 0, out_last = 0.
  - rem = 0, tens = 0.
- Accept at cycle 0. CONV occupies cycles 1..tens+1. The first digit is valid at cycle tens+2.
- Minimum word period with out_ready held high:
  - 1 (IDLE) + tens + 1 (CONV) + number of digits.
  - Single-digit word: 3 cycles.
  - Word 31: 7 cycles.
- Backpressure: out_ready low holds the current EMIT state indefinitely, and no new input is accepted.
- in_valid is ignored outside IDLE, so in_data may change freely while the block is busy.
- Reset mid-word (any state): the word is discarded and out_valid drops immediately. in_ready is 1 from reset deassertion onward.
- out_ready high when out_valid is low has no effect.

## Structure
- Shared package `sm_digit_pkg` holds:
  - the state enum {IDLE, CONV, EMIT_TENS, EMIT_ONES};
  - the localparam DEC_BASE = 10;
  - the BCD digit typedef (4 bits).
- One natural sub-module is `div10_iter`. It is the rem/tens register pair with a load/step interface and a done flag (rem < 10). The top module holds the FSM, the sign logic and the output registers.

## Test plan
- Reset, then `in_data = 6'b000111` (+7) with out_ready = 1:
  - exactly one digit, 7, with neg = 0 and first = last = 1;
  - out_valid at cycle 2 after accept.
- `6'b011111` (+31):
  - digits 3 then 1;
  - first flag on digit 3 only, last flag on digit 1 only, neg = 0;
  - next in_ready 7 cycles after accept.
- `6'b100000` (magnitude ~11111 = 31, negative): digits 3 then 1, neg = 1 on both.
- `6'b111111` (negative zero) → single digit 0, neg = 0. `6'b000000` → single digit 0, neg = 0.
- `6'b010100` (+20) with out_ready held low for 5 cycles while digit 2 is presented:
  - out_digit, out_first and out_neg stay stable;
  - in_ready stays 0 and a pulsed in_valid is ignored;
  - after release, digit 0 follows with last = 1.
- rst asserted during CONV of +25:
  - out_valid = 0 and in_ready = 1 immediately;
  - a following +4 emits only digit 4, with no stale tens digit.
